// File: rtl/operand_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_capture_pkg
// Description : Shared constants for the operand capture block: FSM state
//               encodings and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
package operand_capture_pkg;

    // FSM state encodings (2'b11 is illegal and recovers to C_WAIT_A)
    localparam logic [1:0] C_WAIT_A = 2'b00;
    localparam logic [1:0] C_WAIT_B = 2'b01;
    localparam logic [1:0] C_SHOW   = 2'b10;

    // Defaults: 2-bit operands, 10 ms debounce at 50 MHz, 2-flop synchronisers
    localparam int C_DEFAULT_WIDTH           = 2;
    localparam int C_DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int C_DEFAULT_SYNC_STAGES     = 2;

endpackage : operand_capture_pkg
`default_nettype wire

// File: rtl/operand_capture_debounce_sync.sv
`default_nettype none
// ============================================================================
// Module      : debounce_sync
// Description : Synchroniser plus debouncer for one active-low push-button.
//               Produces the debounced level and a one-cycle registered
//               press pulse on each accepted 1->0 transition.
// Ports       : clk, rst (async, active-high)
//               raw_n       - raw bouncy active-low button input
//               level       - debounced button level (1 = released)
//               press_pulse - one-cycle pulse the cycle after level falls
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_sync
    import operand_capture_pkg::*;
#(
    parameter int SYNC_STAGES     = C_DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = C_DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press_pulse
);

    // Counter only has to reach DEBOUNCE_CYCLES-1
    localparam int                 C_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [C_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   r_pulse;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync    <= '1;
            r_cnt     <= '0;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_pulse   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], raw_n};
            r_level_d <= r_level;
            // Press is seen one cycle after the debounced level falls
            r_pulse   <= r_level_d & ~r_level;
            if (w_synced != r_level) begin
                if (r_cnt == C_CNT_MAX) begin
                    r_level <= w_synced;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end else begin
                // Any agreeing cycle restarts the stability window
                r_cnt <= '0;
            end
        end
    end

    assign level       = r_level;
    assign press_pulse = r_pulse;

endmodule : debounce_sync
`default_nettype wire

// File: rtl/operand_capture.sv
`default_nettype none
// ============================================================================
// Module      : operand_capture
// Description : Captures operand A then operand B from the slide switches on
//               successive debounced load presses and holds them on
//               registered outputs feeding the ripple adder. A clear press
//               returns the sequence to the start.
// Ports       : clk, rst (async, active-high)
//               sw_in      - raw switch operand value
//               load_btn_n - raw load button, active-low
//               clr_btn_n  - raw clear button, active-low
//               op_a, op_b - captured operands
//               ops_valid  - both operands captured
//               state_dbg  - FSM state for LEDs
// Revision    : 1.0 - initial release
// ============================================================================
module operand_capture
    import operand_capture_pkg::*;
#(
    parameter int WIDTH           = C_DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = C_DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = C_DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             load_btn_n,
    input  logic             clr_btn_n,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             ops_valid,
    output logic [1:0]       state_dbg
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sw_sync;
    logic [WIDTH-1:0]                  w_sw;
    logic [1:0]                        r_state;
    logic [WIDTH-1:0]                  r_op_a;
    logic [WIDTH-1:0]                  r_op_b;
    logic                              r_valid;
    logic                              w_load_press;
    logic                              w_clr_press;
    logic                              w_load_level;
    logic                              w_clr_level;
    logic                              w_unused_levels;

    // Debounced levels are not needed here; only press events drive the FSM
    assign w_unused_levels = w_load_level ^ w_clr_level;

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk         (clk),
        .rst         (rst),
        .raw_n       (load_btn_n),
        .level       (w_load_level),
        .press_pulse (w_load_press)
    );

    debounce_sync #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk         (clk),
        .rst         (rst),
        .raw_n       (clr_btn_n),
        .level       (w_clr_level),
        .press_pulse (w_clr_press)
    );

    // Switch value synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_sync <= '1;
        end else begin
            r_sw_sync <= {r_sw_sync[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign w_sw = r_sw_sync[SYNC_STAGES-1];

    // Capture FSM; clear has priority over a coincident load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_WAIT_A;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_valid <= 1'b0;
        end else if (w_clr_press) begin
            r_state <= C_WAIT_A;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                C_WAIT_A: begin
                    if (w_load_press) begin
                        r_op_a  <= w_sw;
                        r_state <= C_WAIT_B;
                    end
                end
                C_WAIT_B: begin
                    if (w_load_press) begin
                        r_op_b  <= w_sw;
                        r_valid <= 1'b1;
                        r_state <= C_SHOW;
                    end
                end
                C_SHOW: begin
                    // A load while showing starts a fresh pair
                    if (w_load_press) begin
                        r_op_a  <= w_sw;
                        r_op_b  <= '0;
                        r_valid <= 1'b0;
                        r_state <= C_WAIT_B;
                    end
                end
                default: begin
                    r_state <= C_WAIT_A;
                    r_op_a  <= '0;
                    r_op_b  <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign ops_valid = r_valid;
    assign state_dbg = r_state;

endmodule : operand_capture
`default_nettype wire

// File: tb/tb_operand_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_capture
// Description : Self-checking bench for operand_capture with
//               DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_capture;

    localparam int C_WIDTH = 2;
    localparam int C_DEB   = 4;
    localparam int C_SYNC  = 2;
    localparam int C_LAT   = C_SYNC + C_DEB + 2;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       v;
        logic [1:0] st;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [C_WIDTH-1:0] sw_in;
    logic               load_btn_n;
    logic               clr_btn_n;
    logic [C_WIDTH-1:0] op_a;
    logic [C_WIDTH-1:0] op_b;
    logic               ops_valid;
    logic [1:0]         state_dbg;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t cur;
    exp_t q[$];

    always #5 clk = ~clk;

    operand_capture #(
        .WIDTH           (C_WIDTH),
        .DEBOUNCE_CYCLES (C_DEB),
        .SYNC_STAGES     (C_SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw_in),
        .load_btn_n (load_btn_n),
        .clr_btn_n  (clr_btn_n),
        .op_a       (op_a),
        .op_b       (op_b),
        .ops_valid  (ops_valid),
        .state_dbg  (state_dbg)
    );

    // Reference behaviour of the capture sequence
    task automatic model_reset();
        cur = '{a: 2'd0, b: 2'd0, v: 1'b0, st: 2'b00};
    endtask

    task automatic model_load(input logic [1:0] sw);
        case (cur.st)
            2'b00:   begin cur.a = sw; cur.st = 2'b01; end
            2'b01:   begin cur.b = sw; cur.v = 1'b1; cur.st = 2'b10; end
            default: begin cur.a = sw; cur.b = 2'd0; cur.v = 1'b0; cur.st = 2'b01; end
        endcase
    endtask

    task automatic check(input exp_t e, input string tag);
        vectors++;
        assert (op_a === e.a) else begin
            miscompares++;
            $error("FAIL %s op_a: got %0d expected %0d", tag, op_a, e.a);
        end
        vectors++;
        assert (op_b === e.b) else begin
            miscompares++;
            $error("FAIL %s op_b: got %0d expected %0d", tag, op_b, e.b);
        end
        vectors++;
        assert (ops_valid === e.v) else begin
            miscompares++;
            $error("FAIL %s ops_valid: got %b expected %b", tag, ops_valid, e.v);
        end
        vectors++;
        assert (state_dbg === e.st) else begin
            miscompares++;
            $error("FAIL %s state_dbg: got %b expected %b", tag, state_dbg, e.st);
        end
    endtask

    // Drive a clean press (load and/or clear), check exact latency, then release
    task automatic do_press(input bit ld, input bit cl, input int hold,
                            input bit glitchy, input string tag);
        exp_t prev;
        exp_t e;
        @(negedge clk);
        prev = cur;
        if (cl) model_reset();
        else if (ld) model_load(sw_in);
        q.push_back(cur);
        load_btn_n = ~ld;
        clr_btn_n  = ~cl;
        repeat (C_LAT - 1) @(posedge clk);
        #1 check(prev, {tag, "_early"});
        @(posedge clk);
        #1;
        e = q.pop_front();
        check(e, tag);
        repeat (hold - C_LAT) @(posedge clk);
        @(negedge clk);
        if (glitchy) begin
            load_btn_n = 1'b1; repeat (2) @(negedge clk);
            load_btn_n = 1'b0; repeat (2) @(negedge clk);
            load_btn_n = 1'b1; repeat (2) @(negedge clk);
            load_btn_n = 1'b0; repeat (2) @(negedge clk);
        end
        load_btn_n = 1'b1;
        clr_btn_n  = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        sw_in      = 2'b00;
        load_btn_n = 1'b1;
        clr_btn_n  = 1'b1;
        model_reset();
        #1 check(cur, "reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pair capture
        sw_in = 2'b10;
        do_press(1'b1, 1'b0, 10, 1'b0, "cap_a");
        sw_in = 2'b11;
        do_press(1'b1, 1'b0, 10, 1'b0, "cap_b");
        vectors++;
        assert (({1'b0, op_a} + {1'b0, op_b}) === 3'b101) else begin
            miscompares++;
            $error("FAIL adder_sum: got %b expected 101", {1'b0, op_a} + {1'b0, op_b});
        end

        // Restart from SHOW
        sw_in = 2'b01;
        do_press(1'b1, 1'b0, 10, 1'b0, "restart");

        // Finish the pair, then a lone clear from SHOW
        sw_in = 2'b10;
        do_press(1'b1, 1'b0, 10, 1'b0, "cap_b2");
        do_press(1'b0, 1'b1, 10, 1'b0, "clear_show");

        // Clear priority in WAIT_B with op_a=3
        sw_in = 2'b11;
        do_press(1'b1, 1'b0, 10, 1'b0, "cap_a3");
        do_press(1'b1, 1'b1, 10, 1'b0, "clr_prio");

        // Bounce rejection: low 3, high 2, low 3, high
        @(negedge clk);
        load_btn_n = 1'b0; repeat (3) @(negedge clk);
        load_btn_n = 1'b1; repeat (2) @(negedge clk);
        load_btn_n = 1'b0; repeat (3) @(negedge clk);
        load_btn_n = 1'b1; repeat (20) @(negedge clk);
        check(cur, "bounce");

        // Long hold with glitchy release: exactly one capture
        sw_in = 2'b01;
        do_press(1'b1, 1'b0, 100, 1'b1, "hold");
        repeat (30) @(negedge clk);
        check(cur, "hold_after");

        // Switch changes alone do nothing
        sw_in = 2'b10;
        repeat (10) @(negedge clk);
        check(cur, "sw_only");

        // Reach SHOW, then async reset between edges
        do_press(1'b1, 1'b0, 10, 1'b0, "cap_b3");
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check(cur, "async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sw_in = 2'b11;
        do_press(1'b1, 1'b0, 10, 1'b0, "post_rst");

        vectors++;
        assert (q.size() === 0) else begin
            miscompares++;
            $error("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_operand_capture
`default_nettype wire

// File: doc/operand_capture.md
Name: operand_capture

Overview:
- Upstream stage for the 2-bit ripple adder.
- Takes operand values from board slide switches and a push-button, captures operand A then operand B on successive debounced presses, and holds both stable on registered outputs.
- The registered outputs drive the adder's A/B inputs directly. A separate clear button returns the sequence to the start.
- Raw board inputs are asynchronous and bouncy; this block owns synchronisation and debouncing.

Parameters:
- WIDTH, 2, operand width in bits; must match the adder's operand width.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed before a button level change is accepted (10 ms at 50 MHz); minimum 2.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; minimum 2.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sw_in  input  WIDTH  raw slide-switch operand value, asynchronous to clk.
- load_btn_n  input  1  raw load push-button, active-low, bouncy.
- clr_btn_n  input  1  raw clear push-button, active-low, bouncy.
- op_a  output  WIDTH  captured operand A, to adder input A.
- op_b  output  WIDTH  captured operand B, to adder input B.
- ops_valid  output  1  high while op_a and op_b are both captured and the adder sum is meaningful.
- state_dbg  output  2  current FSM state encoding, for LEDs.

Behaviour:
- Reset (async, active-high):
  - op_a=0, op_b=0, ops_valid=0, state=WAIT_A (state_dbg=2'b00).
  - All synchroniser flops = 1 (released). Debounced levels = 1. Debounce counters = 0.
  - Outputs change immediately on rst assertion, without waiting for a clk edge, including mid-sequence.
- Synchronisers:
  - sw_in passes through SYNC_STAGES flops before use.
  - Each button passes through SYNC_STAGES flops.
- Debounce (per button):
  - The counter increments each cycle the synced input differs from the debounced level. It clears on any cycle where they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
  - A press event is a 1-cycle registered pulse, asserted the cycle after the debounced level goes 1->0.
  - Releases (0->1) generate no event.
  - Pulses shorter than DEBOUNCE_CYCLES cycles are ignored entirely.
- Latency: a clean press reaches the outputs exactly SYNC_STAGES+DEBOUNCE_CYCLES+2 rising edges after the first edge that samples load_btn_n=0.
- FSM, on each load press (no clear press in the same cycle):
  - WAIT_A (00): op_a<=synced sw, go to WAIT_B; ops_valid stays 0.
  - WAIT_B (01): op_b<=synced sw, ops_valid<=1, go to SHOW.
  - SHOW (10): op_a<=synced sw, op_b<=0, ops_valid<=0, go to WAIT_B. This starts a new pair.
  - Encoding 11 is illegal; it recovers to WAIT_A with all outputs cleared on the next edge.
- Clear press, from any state: op_a<=0, op_b<=0, ops_valid<=0, go to WAIT_A.
- Simultaneous load and clear presses in the same cycle: clear wins, load is dropped.
- A held button produces exactly one event; no auto-repeat.
- op_a, op_b and ops_valid are all registered. They change only on a load or clear event edge, or on reset.
- Switch changes without a press have no effect on outputs.

Decomposition:
- Shared package:
  - State encodings WAIT_A=2'b00, WAIT_B=2'b01, SHOW=2'b10.
  - Default WIDTH and default DEBOUNCE_CYCLES constants.
- One sub-module: debounce_sync.
  - Parameters SYNC_STAGES and DEBOUNCE_CYCLES.
  - Ports: clk, rst, raw_n in, level out, press_pulse out.
  - Instantiated twice: load button and clear button.
- The counter width is derived from DEBOUNCE_CYCLES inside debounce_sync.
- The sw_in synchroniser sits in the top level.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2.
- Pair capture: sw=2'b10, clean load press; then sw=2'b11, clean load press -> op_a=2, op_b=3, ops_valid=1, state_dbg=2'b10, downstream adder sum=3'b101. Each capture lands exactly 8 edges after its press is sampled.
- Bounce rejection: load_btn_n low for 3 cycles, high 2, low 3, then high -> no press event, state_dbg stays 2'b00, op_a=0.
- Hold and release bounce: load_btn_n held low 100 cycles, then released with 2-cycle glitches -> exactly one capture (state WAIT_A->WAIT_B), no further transition.
- Restart from SHOW: in SHOW with op_a=2, op_b=3, set sw=2'b01 and press load -> op_a=1, op_b=0, ops_valid=0, state_dbg=2'b01.
- Clear priority: load and clear pressed on the same cycle while in WAIT_B with op_a=3 -> op_a=0, op_b=0, ops_valid=0, state_dbg=2'b00.
- Async reset mid-operation: assert rst between clk edges while in SHOW -> outputs 0 and state_dbg=2'b00 before the next edge. After deassertion, the first clean press captures A.
